ifu: RTL and testbench
======================

IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, SHALL be the first fetch address after reset.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  32  fetch address (= pc).
- imem_resp_valid  in  1  response data valid.
- imem_resp_data  in  32  fetched word.
- imem_resp_err  in  1  access fault, qualified by imem_resp_valid.
- inst_valid  out  1  instruction available to decode/extender.
- inst_ready  in  1  decode accepts instruction.
- inst  out  32  held instruction word (feeds instr of the immediate extender).
- inst_pc  out  32  address of inst.
- redirect_valid  in  1  control-flow redirect.
- redirect_pc  in  32  redirect target.
- fault  out  1  sticky fetch fault.
- fetch_count  out  32  accepted-instruction counter.

Function
REQ-003 FSM states SHALL be REQ, WAIT, HOLD, FAULT.
REQ-004 In REQ, imem_req_valid SHALL be 1 unless redirect_valid=1 that cycle, when it SHALL be 0 (combinational suppression).
REQ-005 In REQ with imem_req_valid=1 and imem_req_ready=1, next state SHALL be WAIT.
REQ-006 imem_resp_valid SHALL be ignored in every state except WAIT, including the cycle the request is accepted.
REQ-007 In WAIT, on imem_resp_valid=1 with imem_resp_err=0: inst<=imem_resp_data, inst_pc<=pc, next state HOLD.
REQ-008 In WAIT, on imem_resp_valid=1 with imem_resp_err=1: next state FAULT; inst unchanged.
REQ-009 inst_valid SHALL be 1 only in HOLD; inst and inst_pc SHALL be stable while inst_valid=1 and inst_ready=0.
REQ-010 In HOLD, on inst_ready=1: fetch_count+=1, pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC->0), next state REQ.
REQ-011 Minimum latency: request accepted cycle N, response cycle N+1, inst_valid=1 cycle N+2; one instruction per 3 cycles at best.
REQ-012 redirect_valid SHALL have priority over all other transitions in every state: pc<=redirect_pc, next state REQ.
REQ-013 Redirect in WAIT SHALL set a drop flag; that outstanding response, when it arrives in a later REQ/WAIT, SHALL be discarded and no new request issued until it returns.
REQ-014 Redirect in HOLD with inst_ready=1 the same cycle: handshake completes (fetch_count increments), pc takes redirect_pc, not pc+4.
REQ-015 Redirect in HOLD with inst_ready=0: held instruction discarded, inst_valid=0 next cycle.
REQ-016 redirect_pc[1:0]!=0 SHALL send the FSM to FAULT instead of REQ, with pc<=redirect_pc.
REQ-017 fault SHALL be 1 exactly in FAULT; FAULT exits only on a valid aligned redirect (to REQ) or reset.
REQ-018 imem_addr SHALL equal pc in all states.
REQ-019 fetch_count SHALL wrap 32'hFFFF_FFFF->0.

Reset
REQ-020 On rst=1, asynchronously: state=REQ, pc=RESET_PC, inst=0, inst_pc=0, fetch_count=0, drop flag=0; inst_valid=0, fault=0; imem_req_valid=1 after rst deasserts.
REQ-021 Reset mid-WAIT SHALL abandon the outstanding response; a late response arriving in REQ SHALL be ignored per REQ-006.

Verification
REQ-022 Reset, ready=1, response 32'h0000_0093 one cycle later -> inst_valid at cycle 2, inst=32'h0000_0093, inst_pc=32'h8000_0000; after inst_ready, imem_addr=32'h8000_0004, fetch_count=1.
REQ-023 inst_ready held 0 for 5 cycles in HOLD -> inst/inst_pc stable, no new imem request.
REQ-024 Redirect to 32'h8000_0100 during WAIT -> stale response discarded, next delivered inst_pc=32'h8000_0100.
REQ-025 Response with imem_resp_err=1 -> fault=1, no inst_valid; redirect to 32'h8000_0000 -> fault=0, fetch resumes.
REQ-026 Redirect to 32'h8000_0102 -> FAULT; redirect with inst_ready in the same HOLD cycle -> fetch_count+1 and next imem_addr=redirect_pc.
REQ-027 pc=32'hFFFF_FFFC accepted -> imem_addr=0 next fetch; rst asserted mid-WAIT -> immediate return to REQ at RESET_PC.

Source files
------------

// File: rtl/ifu_if.sv
// Bundles the IFU's memory, decode and redirect signals.
// The master modport is the IFU side; the slave modport is its environment.
interface ifu_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fault;
  logic [31:0] fetch_count;

  modport master (
    output imem_req_valid, imem_addr, inst_valid, inst, inst_pc, fault, fetch_count,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
           inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_addr, inst_valid, inst, inst_pc, fault, fetch_count,
    output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
           inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding imem request, a single held instruction,
// redirect handling with stale-response dropping, and a sticky fault state.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input logic clk,
  input logic rst,
  ifu_if.master bus
);

  localparam logic [1:0] ST_REQ   = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  logic [31:0] pc_r;
  logic [31:0] pc_nxt_s;
  logic [31:0] inst_r;
  logic [31:0] inst_pc_r;
  logic [31:0] count_r;
  logic        drop_r;
  logic        drop_nxt_s;
  logic        load_s;
  logic        count_inc_s;
  logic        req_valid_s;

  // A request is withheld while a dropped response is still in flight.
  assign req_valid_s = (state_r == ST_REQ) && !drop_r && !bus.redirect_valid;

  // Next-state, next-pc, instruction load and counter-increment decisions.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    load_s      = 1'b0;
    count_inc_s = 1'b0;
    if (bus.redirect_valid) begin
      pc_nxt_s = bus.redirect_pc;
      if (bus.redirect_pc[1:0] != 2'b00) begin
        state_nxt_s = ST_FAULT;
      end else begin
        state_nxt_s = ST_REQ;
      end
      if ((state_r == ST_HOLD) && bus.inst_ready) begin
        count_inc_s = 1'b1;
      end else begin
        count_inc_s = 1'b0;
      end
    end else begin
      case (state_r)
        ST_REQ: begin
          if (req_valid_s && bus.imem_req_ready) begin
            state_nxt_s = ST_WAIT;
          end else begin
            state_nxt_s = ST_REQ;
          end
        end
        ST_WAIT: begin
          if (bus.imem_resp_valid && bus.imem_resp_err) begin
            state_nxt_s = ST_FAULT;
          end else if (bus.imem_resp_valid) begin
            state_nxt_s = ST_HOLD;
            load_s      = 1'b1;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (bus.inst_ready) begin
            state_nxt_s = ST_REQ;
            pc_nxt_s    = pc_r + 32'd4;
            count_inc_s = 1'b1;
          end else begin
            state_nxt_s = ST_HOLD;
          end
        end
        ST_FAULT: state_nxt_s = ST_FAULT;
        default:  state_nxt_s = ST_REQ;
      endcase
    end
  end

  // Drop flag: set when a redirect abandons an outstanding request, cleared when it returns.
  always_comb begin
    drop_nxt_s = drop_r;
    if (bus.redirect_valid && (state_r == ST_WAIT)) begin
      drop_nxt_s = !bus.imem_resp_valid;
    end else if (drop_r && bus.imem_resp_valid) begin
      drop_nxt_s = 1'b0;
    end else begin
      drop_nxt_s = drop_r;
    end
  end

  // State, pc, held instruction and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_REQ;
      pc_r      <= RESET_PC;
      inst_r    <= 32'd0;
      inst_pc_r <= 32'd0;
      count_r   <= 32'd0;
      drop_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      drop_r  <= drop_nxt_s;
      if (load_s) begin
        inst_r    <= bus.imem_resp_data;
        inst_pc_r <= pc_r;
      end
      if (count_inc_s) begin
        count_r <= count_r + 32'd1;
      end
    end
  end

  assign bus.imem_req_valid = req_valid_s;
  assign bus.imem_addr      = pc_r;
  assign bus.inst_valid     = (state_r == ST_HOLD);
  assign bus.fault          = (state_r == ST_FAULT);
  assign bus.inst           = inst_r;
  assign bus.inst_pc        = inst_pc_r;
  assign bus.fetch_count    = count_r;

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed scenarios plus a randomized memory/decode environment,
// all checked against a transaction-level model of the fetch unit.
module tb_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifu_if bus ();
  ifu #(.RESET_PC(RST_PC)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  // Model: pc, optional held instruction, sticky fault, count, one outstanding request
  logic [31:0] m_pc, m_inst, m_ipc, m_cnt;
  bit          m_held, m_fault, m_out, m_want;

  typedef struct { logic [31:0] addr; int dly; } mem_t;
  mem_t mem_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_inst = 32'd0; m_ipc = 32'd0; m_cnt = 32'd0;
    m_held = 1'b0; m_fault = 1'b0; m_out = 1'b0; m_want = 1'b0;
    mem_q.delete();
  endtask

  task automatic drive_idle();
    bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0; bus.imem_resp_data = 32'd0;
    bus.imem_resp_err = 1'b0; bus.inst_ready = 1'b0; bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    #1;
    chk("rst_addr", bus.imem_addr, RST_PC);
    chk("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rst_fault", {31'd0, bus.fault}, 32'd0);
    chk("rst_inst", bus.inst, 32'd0);
    chk("rst_inst_pc", bus.inst_pc, 32'd0);
    chk("rst_count", bus.fetch_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: drive inputs, compare outputs with the model, advance the model.
  task automatic step(input bit rdy, input bit rv, input bit re, input logic [31:0] rd,
                      input bit ir, input bit rdv, input logic [31:0] rdpc,
                      output bit acc, output logic [31:0] acc_addr);
    bit exp_req;
    @(negedge clk);
    bus.imem_req_ready = rdy; bus.imem_resp_valid = rv; bus.imem_resp_err = re;
    bus.imem_resp_data = rd; bus.inst_ready = ir; bus.redirect_valid = rdv;
    bus.redirect_pc = rdpc;
    #1;
    exp_req = !m_held && !m_fault && !m_out && !rdv;
    chk("req_valid", {31'd0, bus.imem_req_valid}, {31'd0, exp_req});
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("inst_valid", {31'd0, bus.inst_valid}, {31'd0, m_held});
    chk("fault", {31'd0, bus.fault}, {31'd0, m_fault});
    chk("fetch_count", bus.fetch_count, m_cnt);
    if (m_held) begin
      chk("inst", bus.inst, m_inst);
      chk("inst_pc", bus.inst_pc, m_ipc);
    end
    acc = bus.imem_req_valid && rdy;
    acc_addr = bus.imem_addr;
    if (rdv) begin
      if (m_held && ir) m_cnt = m_cnt + 32'd1;
      if (m_out && rv) m_out = 1'b0;
      else if (m_out) m_want = 1'b0;
      m_held  = 1'b0;
      m_fault = (rdpc[1:0] != 2'b00);
      m_pc    = rdpc;
    end else if (exp_req && rdy) begin
      m_out = 1'b1; m_want = 1'b1;
    end else if (m_out && rv) begin
      if (m_want && re) m_fault = 1'b1;
      else if (m_want) begin m_held = 1'b1; m_inst = rd; m_ipc = m_pc; end
      m_out = 1'b0;
    end else if (m_held && ir) begin
      m_cnt = m_cnt + 32'd1; m_pc = m_pc + 32'd4; m_held = 1'b0;
    end
  endtask

  bit          a;
  logic [31:0] aa;
  logic [31:0] cnt_before;

  task automatic idle(); step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, a, aa); endtask
  task automatic accept(); step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, a, aa); endtask
  task automatic respond(input logic [31:0] d, input bit e); step(1'b0, 1'b1, e, d, 1'b0, 1'b0, 32'd0, a, aa); endtask
  task automatic take(); step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, a, aa); endtask
  task automatic redir(input logic [31:0] t, input bit ir); step(1'b0, 1'b0, 1'b0, 32'd0, ir, 1'b1, t, a, aa); endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    model_reset();
    do_reset();

    // Basic fetch: accept, response next cycle, instruction held two cycles after accept
    accept();
    respond(32'h0000_0093, 1'b0);
    idle();
    chk("d_inst_valid", {31'd0, bus.inst_valid}, 32'd1);
    chk("d_inst", bus.inst, 32'h0000_0093);
    chk("d_inst_pc", bus.inst_pc, 32'h8000_0000);
    take();
    idle();
    chk("d_next_addr", bus.imem_addr, 32'h8000_0004);
    chk("d_count1", bus.fetch_count, 32'd1);

    // Back-pressure in HOLD: nothing moves and no request issues
    accept();
    respond(32'h0010_0113, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, a, aa);
      chk("bp_inst", bus.inst, 32'h0010_0113);
      chk("bp_inst_pc", bus.inst_pc, 32'h8000_0004);
      chk("bp_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
    end
    take();

    // Redirect while waiting: stale response dropped, fetch resumes at target
    accept();
    redir(32'h8000_0100, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, a, aa);
    chk("drop_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0, a, aa);
    chk("drop_no_inst", {31'd0, bus.inst_valid}, 32'd0);
    accept();
    chk("drop_addr", bus.imem_addr, 32'h8000_0100);
    respond(32'h0020_0113, 1'b0);
    idle();
    chk("drop_inst_pc", bus.inst_pc, 32'h8000_0100);
    chk("drop_inst", bus.inst, 32'h0020_0113);
    take();

    // Access fault, then recovery via aligned redirect
    accept();
    respond(32'h0000_0000, 1'b1);
    idle();
    chk("err_fault", {31'd0, bus.fault}, 32'd1);
    chk("err_no_inst", {31'd0, bus.inst_valid}, 32'd0);
    idle();
    chk("err_sticky", {31'd0, bus.fault}, 32'd1);
    redir(32'h8000_0000, 1'b0);
    idle();
    chk("rec_fault", {31'd0, bus.fault}, 32'd0);
    chk("rec_req", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("rec_addr", bus.imem_addr, 32'h8000_0000);
    accept();
    respond(32'h0000_0013, 1'b0);
    take();

    // Misaligned redirect faults; redirect with same-cycle handshake counts
    redir(32'h8000_0102, 1'b0);
    idle();
    chk("mis_fault", {31'd0, bus.fault}, 32'd1);
    chk("mis_addr", bus.imem_addr, 32'h8000_0102);
    redir(32'h8000_0200, 1'b0);
    accept();
    respond(32'h0000_0033, 1'b0);
    cnt_before = m_cnt;
    redir(32'h8000_0300, 1'b1);
    idle();
    chk("rh_count", bus.fetch_count, cnt_before + 32'd1);
    chk("rh_addr", bus.imem_addr, 32'h8000_0300);
    chk("rh_no_inst", {31'd0, bus.inst_valid}, 32'd0);
    accept();
    respond(32'h0000_0073, 1'b0);
    redir(32'h8000_0400, 1'b0);
    idle();
    chk("rd_discard", {31'd0, bus.inst_valid}, 32'd0);
    chk("rd_count", bus.fetch_count, cnt_before + 32'd1);

    // pc wrap at top of address space
    redir(32'hFFFF_FFFC, 1'b0);
    accept();
    respond(32'h0000_0013, 1'b0);
    take();
    idle();
    chk("wrap_addr", bus.imem_addr, 32'h0000_0000);

    // Asynchronous reset in WAIT; late response then ignored
    accept();
    #6;
    chk("w_in_wait", {31'd0, bus.imem_req_valid}, 32'd0);
    drive_idle();
    rst = 1'b1;
    #1;
    chk("ar_addr", bus.imem_addr, RST_PC);
    chk("ar_req", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("ar_count", bus.fetch_count, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b1, 1'b0, 32'h0BAD_0BAD, 1'b0, 1'b0, 32'd0, a, aa);
    idle();
    chk("late_ignored", {31'd0, bus.inst_valid}, 32'd0);
    chk("late_addr", bus.imem_addr, RST_PC);

    // Randomized traffic with a latency-varying memory
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bit rdy, rv, re, ir, rdv;
      logic [31:0] rd, rdpc;
      rdy = ($urandom_range(0, 3) != 0);
      rv = 1'b0; re = 1'b0; rd = $urandom();
      if (mem_q.size() != 0) begin
        if (mem_q[0].dly == 0) begin
          rv = 1'b1;
          rd = mem_word(mem_q[0].addr);
          re = ($urandom_range(0, 15) == 0);
          void'(mem_q.pop_front());
        end else begin
          mem_q[0].dly--;
        end
      end else begin
        rv = ($urandom_range(0, 19) == 0);
        re = $urandom_range(0, 1);
      end
      ir  = ($urandom_range(0, 2) != 0);
      rdv = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 9) == 0) rdpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
      else rdpc = 32'h8000_0000 + 32'($urandom_range(0, 255) * 4);
      if ($urandom_range(0, 7) == 0) rdpc = rdpc + 32'($urandom_range(1, 3));
      step(rdy, rv, re, rd, ir, rdv, rdpc, a, aa);
      if (a) mem_q.push_back('{addr: aa, dly: $urandom_range(0, 2)});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
